motion_recorder: RTL and testbench

Parametrised record/playback store for multi-channel servo duty values. It captures one NCH-channel duty vector per capture strobe while recording, then replays the stored sequence at a programmable step rate, either looped or one-shot. It sits between the button/duty-generation logic and the PWM generators, and supersedes the fixed 2-channel, 256-entry recorder.

---
 rtl/motion_rec_pkg.sv | 33 +++
 rtl/motion_rec_mem.sv | 29 ++
 rtl/motion_recorder.sv | 170 +++++++++++++++++
 tb/tb_motion_recorder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/motion_rec_pkg.sv
// motion_rec_pkg: shared state encoding and size helpers for the motion recorder.
package motion_rec_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_NCH        = 2;
  localparam int DEF_DW         = 6;
  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int DEF_TICK_W     = 12;

  // Number of stored samples for a given address width.
  function automatic int depth_of(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  // Len must be able to hold the value DEPTH, hence one extra bit.
  function automatic int len_w_of(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // Width of one packed duty vector (channel 0 in the LSBs).
  function automatic int vec_w_of(input int nch, input int dw);
    return nch * dw;
  endfunction

endpackage

// File: rtl/motion_rec_mem.sv
// motion_rec_mem: simple dual-port synchronous RAM, one write port and one
// registered read port, written so it maps onto a block RAM.
module motion_rec_mem
  import motion_rec_pkg::*;
#(
  parameter int AW = DEF_DEPTH_LOG2,
  parameter int W  = vec_w_of(DEF_NCH, DEF_DW)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [depth_of(AW)];

  // Write port: contents are never cleared, the owner tracks valid length.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port, read-before-write on address collisions.
  always_ff @(posedge clk) begin
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/motion_recorder.sv
// motion_recorder: records NCH-channel duty vectors on Capture edges and
// replays them at Rate+1 cycles per sample, looped or one-shot.
// Optional feature macro: MOTION_REC_UNDO_EN (Undo rising edge drops the
// last sample while recording).
module motion_recorder
  import motion_rec_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int DW         = DEF_DW,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TICK_W     = DEF_TICK_W
) (
  input  logic                sysclk,
  input  logic                Reset_Sw,
  input  logic                Storage_Sw,
  input  logic                Capture,
  input  logic                Undo,
  input  logic                Play_En,
  input  logic                One_Shot,
  input  logic [TICK_W-1:0]   Rate,
  input  logic [NCH*DW-1:0]   Duty_In,
  output logic [NCH*DW-1:0]   DC_Out,
  output logic [DEPTH_LOG2:0] Len,
  output logic                Full,
  output logic                Playing,
  output logic                Done
);

  localparam int AW    = DEPTH_LOG2;
  localparam int LEN_W = len_w_of(DEPTH_LOG2);
  localparam int VEC_W = vec_w_of(NCH, DW);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(depth_of(DEPTH_LOG2));

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_m1;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              one_shot_q, one_shot_d;
  logic              cap_prev_q;
  logic [VEC_W-1:0]  duty_q;
  logic [VEC_W-1:0]  rd_data;
  logic              cap_rise, full, at_last, wr_en;

`ifdef MOTION_REC_UNDO_EN
  logic undo_prev_q;
  logic undo_rise;
  assign undo_rise = Undo & ~undo_prev_q;
`else
  logic unused_undo;
  assign unused_undo = Undo;
`endif

  motion_rec_mem #(.AW(AW), .W(VEC_W)) u_mem (
    .clk   (sysclk),
    .we    (wr_en && !Reset_Sw),
    .waddr (len_q[AW-1:0]),
    .wdata (Duty_In),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  // Next-state logic: mode selection, append/undo, and the playback divider.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_addr_d  = rd_addr_q;
    tick_d     = tick_q;
    one_shot_d = one_shot_q;
    wr_en      = 1'b0;
    cap_rise   = Capture & ~cap_prev_q;
    full       = (len_q == DEPTH_LEN);
    len_m1     = len_q - 1'b1;
    at_last    = (len_q != '0) && (rd_addr_q == len_m1[AW-1:0]);

    case (state_q)
      IDLE: begin
        if (Play_En && len_q != '0) begin
          state_d    = PLAY;
          tick_d     = '0;
          one_shot_d = One_Shot;
        end
      end
      RECORD: begin
        if (!Storage_Sw) state_d = IDLE;
        if (cap_rise) begin
          if (!full) begin
            wr_en = 1'b1;
            len_d = len_q + 1'b1;
          end
        end
`ifdef MOTION_REC_UNDO_EN
        else if (undo_rise && len_q != '0) begin
          len_d = len_q - 1'b1;
        end
`endif
      end
      PLAY: begin
        if (!Play_En) begin
          state_d = IDLE;
        end else if (tick_q == Rate) begin
          tick_d = '0;
          if (at_last) begin
            if (one_shot_q) state_d = DONE;
            else            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DONE: begin
        if (!Play_En) state_d = IDLE;
      end
    endcase

    if (Storage_Sw) begin
      state_d = RECORD;
      tick_d  = '0;
    end

    // Parking the read address at 0 outside playback means the RAM already
    // presents sample 0 when PLAY is entered.
    if (state_d == IDLE || state_d == RECORD) rd_addr_d = '0;
  end

  // State, counters and edge-detect history.
  always_ff @(posedge sysclk) begin
    if (Reset_Sw) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_addr_q   <= '0;
      tick_q      <= '0;
      one_shot_q  <= 1'b0;
      cap_prev_q  <= 1'b0;
      duty_q      <= '0;
`ifdef MOTION_REC_UNDO_EN
      undo_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      tick_q      <= tick_d;
      one_shot_q  <= one_shot_d;
      cap_prev_q  <= Capture;
      duty_q      <= Duty_In;
`ifdef MOTION_REC_UNDO_EN
      undo_prev_q <= Undo;
`endif
    end
  end

  // Output mux over registered sources only.
  always_comb begin
    DC_Out = '0;
    case (state_q)
      IDLE:   DC_Out = '0;
      RECORD: DC_Out = duty_q;
      PLAY:   DC_Out = rd_data;
      DONE:   DC_Out = rd_data;
    endcase
  end

  assign Len     = len_q;
  assign Full    = full;
  assign Playing = (state_q == PLAY);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_motion_recorder.sv
// tb_motion_recorder: table-driven, scoreboarded bench for motion_recorder
// built with DEPTH_LOG2=2 so the full condition is reachable quickly.
// Undo expectations follow MOTION_REC_UNDO_EN.
module tb_motion_recorder;

  typedef struct packed {
    logic        rst, sto, cap, und, pen, osh;
    logic [11:0] rate;
    logic [11:0] duty;
    logic        chk_dc;
    logic [11:0] dc;
    logic [2:0]  len;
    logic        play, done, full;
  } vec_t;

`ifdef MOTION_REC_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        Reset_Sw = 1'b1, Storage_Sw = 1'b0, Capture = 1'b0, Undo = 1'b0;
  logic        Play_En = 1'b0, One_Shot = 1'b0;
  logic [11:0] Rate = '0, Duty_In = '0;
  logic [11:0] DC_Out;
  logic [2:0]  Len;
  logic        Full, Playing, Done;

  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;
  vec_t sbq[$];
  int   tagq[$];
  vec_t tbl[$];
  logic [11:0] samp [3];

  motion_recorder #(.NCH(2), .DW(6), .DEPTH_LOG2(2), .TICK_W(12)) dut (
    .sysclk     (sysclk),
    .Reset_Sw   (Reset_Sw),
    .Storage_Sw (Storage_Sw),
    .Capture    (Capture),
    .Undo       (Undo),
    .Play_En    (Play_En),
    .One_Shot   (One_Shot),
    .Rate       (Rate),
    .Duty_In    (Duty_In),
    .DC_Out     (DC_Out),
    .Len        (Len),
    .Full       (Full),
    .Playing    (Playing),
    .Done       (Done)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, sto, cap, und, pen, osh,
                              input logic [11:0] rate, duty,
                              input logic chk, input logic [11:0] dc,
                              input logic [2:0] len, input logic play, done, full);
    vec_t v;
    v.rst = rst; v.sto = sto; v.cap = cap; v.und = und; v.pen = pen; v.osh = osh;
    v.rate = rate; v.duty = duty; v.chk_dc = chk; v.dc = dc;
    v.len = len; v.play = play; v.done = done; v.full = full;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    Reset_Sw   = v.rst;
    Storage_Sw = v.sto;
    Capture    = v.cap;
    Undo       = v.und;
    Play_En    = v.pen;
    One_Shot   = v.osh;
    Rate       = v.rate;
    Duty_In    = v.duty;
    sbq.push_back(v);
    tagq.push_back(vec_no);
    vec_no++;
  endtask

  task automatic cmp(input string name, input int tag, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec%0d: got 0x%03h expected 0x%03h", name, tag, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    int   tag;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e   = sbq.pop_front();
    tag = tagq.pop_front();
    if (e.chk_dc) cmp("dc_out", tag, DC_Out, e.dc);
    cmp("len",     tag, {9'b0, Len},     {9'b0, e.len});
    cmp("playing", tag, {11'b0, Playing}, {11'b0, e.play});
    cmp("done",    tag, {11'b0, Done},    {11'b0, e.done});
    cmp("full",    tag, {11'b0, Full},    {11'b0, e.full});
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(posedge sysclk);
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    for (int i = 0; i < tbl.size(); i++) runVec(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    samp[0] = 12'h041; samp[1] = 12'h082; samp[2] = 12'h0C3;
    #1;

    // Reset, record three samples, return to IDLE.
    tbl.push_back(mk(1,0,0,0,0,0, 0, 12'h000, 1, 12'h000, 0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h041, 1, 12'h041, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h041, 1, 12'h041, 1, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h082, 1, 12'h082, 1, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h082, 1, 12'h082, 2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h0C3, 1, 12'h0C3, 2, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h0C3, 1, 12'h0C3, 3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, 12'h0C3, 1, 12'h000, 3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, 12'h000, 1, 12'h000, 3, 0,0,0));
    runTable();

    // Looped playback, Rate=4: each sample held 5 cycles, wrapping to sample 0.
    $display("[TB] looped playback");
    runVec(mk(0,0,0,0,1,0, 4, 12'h000, 0, 12'h000, 3, 1,0,0));
    for (int k = 1; k <= 20; k++)
      runVec(mk(0,0,0,0,1,0, 4, 12'h000, 1, samp[((k - 1) / 5) % 3], 3, 1,0,0));
    runVec(mk(0,0,0,0,0,0, 4, 12'h000, 1, 12'h000, 3, 0,0,0));

    // One-shot at Rate=0; One_Shot dropped mid-play must not matter.
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 0, 12'h000, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0, 12'h000, 1, 12'h041, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0, 12'h000, 1, 12'h082, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0, 12'h000, 1, 12'h0C3, 3, 0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0, 12'h000, 1, 12'h0C3, 3, 0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0, 12'h000, 1, 12'h0C3, 3, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0, 12'h000, 1, 12'h000, 3, 0,0,0));
    // Reset mid-PLAY, then Play_En with nothing stored stays IDLE.
    tbl.push_back(mk(0,0,0,0,1,0, 2, 12'h000, 0, 12'h000, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 2, 12'h000, 1, 12'h041, 3, 1,0,0));
    tbl.push_back(mk(1,0,0,0,1,0, 2, 12'h000, 1, 12'h000, 0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 2, 12'h000, 1, 12'h000, 0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 2, 12'h000, 1, 12'h000, 0, 0,0,0));
    runTable();

    // Capture held high for 100 cycles stores exactly one sample.
    $display("[TB] held capture and full");
    runVec(mk(0,1,0,0,0,0, 0, 12'h0A5, 1, 12'h0A5, 0, 0,0,0));
    for (int k = 0; k < 100; k++)
      runVec(mk(0,1,1,0,0,0, 0, 12'h0A5, 1, 12'h0A5, 1, 0,0,0));
    // Five more pulses: fills at 4, the rest are ignored.
    for (int p = 1; p <= 5; p++) begin
      logic [11:0] d;
      logic [2:0]  n_before, n_after;
      d        = 12'h0B0 + 12'(p);
      n_before = (p < 4) ? 3'(p) : 3'd4;
      n_after  = (p < 3) ? 3'(p + 1) : 3'd4;
      runVec(mk(0,1,0,0,0,0, 0, d, 1, d, n_before, 0,0, n_before == 3'd4));
      runVec(mk(0,1,1,0,0,0, 0, d, 1, d, n_after,  0,0, n_after == 3'd4));
    end
    // Replay proves sample 0 kept the held value and overflow wrote nothing.
    tbl.push_back(mk(0,0,0,0,0,0, 0, 12'h000, 1, 12'h000, 4, 0,0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 0, 12'h000, 4, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 1, 12'h0A5, 4, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 1, 12'h0B1, 4, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 1, 12'h0B2, 4, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0, 12'h000, 1, 12'h0B3, 4, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0, 12'h000, 1, 12'h000, 4, 0,0,1));
    // Undo: at Len=0, after three captures, and coincident with Capture.
    tbl.push_back(mk(1,0,0,0,0,0, 0, 12'h011, 1, 12'h000, 0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, 0, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 0, 12'h011, 1, 12'h011, 0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h011, 1, 12'h011, 1, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, 1, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h011, 1, 12'h011, 2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, 2, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0, 12'h011, 1, 12'h011, 3, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, 3, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 0, 12'h011, 1, 12'h011, UNDO_ON ? 3'd2 : 3'd3, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0, 12'h011, 1, 12'h011, UNDO_ON ? 3'd2 : 3'd3, 0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0, 0, 12'h011, 1, 12'h011, UNDO_ON ? 3'd3 : 3'd4, 0,0, !UNDO_ON));
    runTable();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
